// File: rtl/e_hilo.sv
// e_hilo -- HI/LO register file with a multi-cycle multiply/divide unit.
// mult/multu take 5 busy cycles, div/divu take 10. The result is computed
// when the operation is accepted, held in temp_hi/temp_lo, and committed to
// HI/LO on the edge where the countdown reaches zero.
// Optional feature macro: HILO_DIV_EN -- when defined, div/divu are
// implemented; when undefined they are no-ops and no divider is built.
`timescale 1ns/1ps
module e_hilo (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  HILO_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HILO_out,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] temp_hi_q, temp_lo_q;
   logic [31:0] hi_q, lo_q;

   // Op decode: ops 4..7 are multiply/divide, bit 1 selects signed, bit 0 divide.
   logic is_md, is_signed, launch;
   assign is_md     = (HILO_op[3:2] == 2'b01);
   assign is_signed = HILO_op[1];

`ifdef HILO_DIV_EN
   assign launch = start && is_md;
`else
   // Without the divider only mult/multu are accepted.
   assign launch = start && is_md && !HILO_op[0];
`endif

   // Multiplier: extend both operands to 64 bits and keep the low 64 bits of
   // the product, which is the exact signed or unsigned 64-bit result.
   logic [63:0] mul_a, mul_b, mul_p;
   assign mul_a = is_signed ? {{32{A[31]}}, A} : {32'd0, A};
   assign mul_b = is_signed ? {{32{B[31]}}, B} : {32'd0, B};
   assign mul_p = mul_a * mul_b;

`ifdef HILO_DIV_EN
   // Divider: divide magnitudes, then restore signs. Quotient is negative when
   // operand signs differ; remainder follows the dividend. Working on
   // magnitudes makes 0x80000000 / -1 wrap to 0x80000000 with remainder 0.
   logic [31:0] abs_a, abs_b, q_mag, r_mag, div_q, div_r;
   logic        neg_q, neg_r, b_zero;
   assign abs_a  = (is_signed && A[31]) ? (32'd0 - A) : A;
   assign abs_b  = (is_signed && B[31]) ? (32'd0 - B) : B;
   assign b_zero = (B == 32'd0);
   assign q_mag  = b_zero ? 32'd0 : (abs_a / abs_b);
   assign r_mag  = b_zero ? 32'd0 : (abs_a % abs_b);
   assign neg_q  = is_signed && (A[31] ^ B[31]);
   assign neg_r  = is_signed && A[31];
   assign div_q  = neg_q ? (32'd0 - q_mag) : q_mag;
   assign div_r  = neg_r ? (32'd0 - r_mag) : r_mag;
`endif

   // Result to latch into temp_hi/temp_lo when an operation is accepted.
   logic [31:0] temp_hi_d, temp_lo_d;
   logic [3:0]  cnt_d;
   always_comb begin
      temp_hi_d = mul_p[63:32];
      temp_lo_d = mul_p[31:0];
      cnt_d     = 4'd5;
`ifdef HILO_DIV_EN
      if (HILO_op[0]) begin
         cnt_d = 4'd10;
         if (b_zero) begin
            // Divide by zero: recommit the current values so HI/LO are unchanged.
            temp_hi_d = hi_q;
            temp_lo_d = lo_q;
         end else begin
            temp_hi_d = div_r;
            temp_lo_d = div_q;
         end
      end
`endif
   end

   // Control FSM, countdown and architectural HI/LO registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         temp_hi_q <= 32'd0;
         temp_lo_q <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (launch) begin
                  temp_hi_q <= temp_hi_d;
                  temp_lo_q <= temp_lo_d;
                  cnt_q     <= cnt_d;
                  state_q   <= BUSY;
               end else if (HILO_op == 4'd2) begin
                  hi_q <= A;
               end else if (HILO_op == 4'd3) begin
                  lo_q <= A;
               end
            end
            BUSY: begin
               // Requests arriving while busy are dropped; the pipeline stalls them.
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  hi_q    <= temp_hi_q;
                  lo_q    <= temp_lo_q;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = (state_q == BUSY);
   assign HI       = hi_q;
   assign LO       = lo_q;
   // Reads see committed values only; in-flight results are not forwarded.
   assign HILO_out = HILO_op[0] ? lo_q : hi_q;

endmodule

// File: tb/tb_e_hilo.sv
// Testbench for e_hilo: scoreboard of expected HI/LO/busy-length per accepted
// operation, popped and compared when busy falls. Handles builds with and
// without HILO_DIV_EN.
`timescale 1ns/1ps
module tb_e_hilo;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  HILO_op;
   logic [31:0] A, B;
   logic        busy;
   logic [31:0] HILO_out, HI, LO;

   e_hilo dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .HILO_op  (HILO_op),
      .A        (A),
      .B        (B),
      .busy     (busy),
      .HILO_out (HILO_out),
      .HI       (HI),
      .LO       (LO)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: 64-bit integer arithmetic.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] h, input logic [31:0] l);
      exp_t        e;
      longint      sa, sb, p;
      logic [63:0] u;
      sa    = longint'(signed'(a));
      sb    = longint'(signed'(b));
      e.hi  = h;
      e.lo  = l;
      e.cyc = 0;
      case (op)
         4'd4: begin
            u = {32'd0, a} * {32'd0, b};
            e.hi = u[63:32]; e.lo = u[31:0]; e.cyc = 5;
         end
         4'd6: begin
            p = sa * sb;
            u = p;
            e.hi = u[63:32]; e.lo = u[31:0]; e.cyc = 5;
         end
`ifdef HILO_DIV_EN
         4'd5: begin
            e.cyc = 10;
            if (b != 32'd0) begin
               e.lo = a / b; e.hi = a % b;
            end
         end
         4'd7: begin
            e.cyc = 10;
            if (b != 32'd0) begin
               p = sa / sb; u = p; e.lo = u[31:0];
               p = sa % sb; u = p; e.hi = u[31:0];
            end
         end
`endif
         default: ;
      endcase
      return e;
   endfunction

   // Launch one mult/div op, count busy cycles, compare against scoreboard.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   n;
      sb_q.push_back(model(op, a, b, m_hi, m_lo));
      start = 1'b1; HILO_op = op; A = a; B = b;
      tick();
      start = 1'b0; HILO_op = 4'd0;
      n = 0;
      while (busy === 1'b1 && n < 30) begin
         n++;
         tick();
      end
      if (sb_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty op=%0d", op);
         return;
      end
      e = sb_q.pop_front();
      checks++;
      if (n !== e.cyc) begin
         errors++;
         $display("FAIL busy_cycles op=%0d got=%0d exp=%0d", op, n, e.cyc);
      end
      checks++;
      if (HI !== e.hi) begin
         errors++;
         $display("FAIL hi op=%0d A=%h B=%h got=%h exp=%h", op, a, b, HI, e.hi);
      end
      checks++;
      if (LO !== e.lo) begin
         errors++;
         $display("FAIL lo op=%0d A=%h B=%h got=%h exp=%h", op, a, b, LO, e.lo);
      end
      m_hi = e.hi; m_lo = e.lo;
      $display("op=%0d A=%h B=%h busy_cycles=%0d HI=%h LO=%h", op, a, b, n, HI, LO);
   endtask

   // mthi (op 2) / mtlo (op 3) with start low.
   task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
      HILO_op = op; A = a; start = 1'b0;
      tick();
      HILO_op = 4'd0;
      if (op == 4'd2) m_hi = a; else m_lo = a;
      checks++;
      if (HI !== m_hi || LO !== m_lo || busy !== 1'b0) begin
         errors++;
         $display("FAIL mt op=%0d got HI=%h LO=%h busy=%b exp HI=%h LO=%h busy=0", op, HI, LO, busy, m_hi, m_lo);
      end
      $display("op=%0d A=%h HI=%h LO=%h", op, a, HI, LO);
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; HILO_op = 4'd0; A = 32'd0; B = 32'd0;
      #2;
      checks++;
      if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0 || HILO_out !== 32'd0) begin
         errors++;
         $display("FAIL reset got HI=%h LO=%h busy=%b out=%h exp all zero", HI, LO, busy, HILO_out);
      end
      tick(); tick();
      reset = 1'b1;
      tick();
      $display("reset released HI=%h LO=%h busy=%b", HI, LO, busy);
   endtask

   task automatic test_mult();
      run_op(4'd6, 32'hFFFFFFFF, 32'd2);
      checks++;
      if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE) begin
         errors++;
         $display("FAIL mult_const got HI=%h LO=%h exp HI=ffffffff LO=fffffffe", HI, LO);
      end
      run_op(4'd4, 32'hFFFFFFFF, 32'd2);
      checks++;
      if (HI !== 32'h00000001 || LO !== 32'hFFFFFFFE) begin
         errors++;
         $display("FAIL multu_const got HI=%h LO=%h exp HI=00000001 LO=fffffffe", HI, LO);
      end
      run_op(4'd6, 32'h80000000, 32'h80000000);
      run_op(4'd4, 32'h80000000, 32'hFFFFFFFF);
   endtask

   task automatic test_mt_read();
      do_mt(4'd3, 32'hCAFEF00D);
      do_mt(4'd2, 32'h12345678);
      HILO_op = 4'd0; #1;
      checks++;
      if (HILO_out !== 32'h12345678) begin
         errors++;
         $display("FAIL mfhi got=%h exp=12345678", HILO_out);
      end
      HILO_op = 4'd1; #1;
      checks++;
      if (HILO_out !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL mflo got=%h exp=cafef00d", HILO_out);
      end
      $display("mfhi/mflo read HI=%h LO=%h", HI, LO);
      // start with a non-md op is ignored
      start = 1'b1; HILO_op = 4'd1; A = 32'h0BADF00D; B = 32'd3;
      tick();
      start = 1'b0; HILO_op = 4'd0;
      checks++;
      if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
         errors++;
         $display("FAIL start_bad_op got busy=%b HI=%h LO=%h exp busy=0 HI=%h LO=%h", busy, HI, LO, m_hi, m_lo);
      end
      $display("start with op=1 ignored busy=%b", busy);
   endtask

   task automatic test_div();
      run_op(4'd7, 32'hFFFFFFF9, 32'd2);
`ifdef HILO_DIV_EN
      checks++;
      if (LO !== 32'hFFFFFFFD || HI !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL div_const got HI=%h LO=%h exp HI=ffffffff LO=fffffffd", HI, LO);
      end
`endif
      run_op(4'd5, 32'd7, 32'd2);
`ifdef HILO_DIV_EN
      checks++;
      if (LO !== 32'd3 || HI !== 32'd1) begin
         errors++;
         $display("FAIL divu_const got HI=%h LO=%h exp HI=00000001 LO=00000003", HI, LO);
      end
`endif
      run_op(4'd7, 32'h80000000, 32'hFFFFFFFF);
      run_op(4'd7, 32'd7, 32'hFFFFFFFE);
      do_mt(4'd3, 32'h0000AAAA);
      run_op(4'd5, 32'h12345678, 32'd0);
      checks++;
      if (LO !== 32'h0000AAAA) begin
         errors++;
         $display("FAIL divu_zero got LO=%h exp 0000aaaa", LO);
      end
   endtask

   task automatic test_ignore_in_busy();
      exp_t e;
      int   n;
      sb_q.push_back(model(4'd6, 32'h00010003, 32'hFFFF0007, m_hi, m_lo));
      start = 1'b1; HILO_op = 4'd6; A = 32'h00010003; B = 32'hFFFF0007;
      tick();
      start = 1'b0; HILO_op = 4'd0;
      n = 0;
      while (busy === 1'b1 && n < 30) begin
         n++;
         if (n == 2) begin
            start = 1'b1; HILO_op = 4'd7; A = 32'd100; B = 32'd7;
         end else if (n == 3) begin
            start = 1'b0; HILO_op = 4'd2; A = 32'hDEADBEEF;
         end else begin
            start = 1'b0; HILO_op = 4'd0;
         end
         tick();
      end
      start = 1'b0; HILO_op = 4'd0;
      e = sb_q.pop_front();
      checks++;
      if (n !== 5) begin
         errors++;
         $display("FAIL ignore_busy_len got=%0d exp=5", n);
      end
      checks++;
      if (HI !== e.hi || LO !== e.lo) begin
         errors++;
         $display("FAIL ignore_busy_result got HI=%h LO=%h exp HI=%h LO=%h", HI, LO, e.hi, e.lo);
      end
      m_hi = e.hi; m_lo = e.lo;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_busy_queued got busy=%b exp=0", busy);
      end
      $display("mult with div/mthi during busy: busy_cycles=%0d HI=%h LO=%h", n, HI, LO);
   endtask

   task automatic test_reset_abort();
      do_mt(4'd2, 32'h55555555);
      do_mt(4'd3, 32'h33333333);
`ifdef HILO_DIV_EN
      start = 1'b1; HILO_op = 4'd7; A = 32'd100; B = 32'd3;
`else
      start = 1'b1; HILO_op = 4'd6; A = 32'd100; B = 32'd3;
`endif
      tick();
      start = 1'b0; HILO_op = 4'd0;
      tick(); tick(); tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_prebusy got busy=%b exp=1", busy);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset got HI=%h LO=%h busy=%b exp 0 0 0", HI, LO, busy);
      end
      tick();
      reset = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      tick();
      checks++;
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         errors++;
         $display("FAIL abort_release got HI=%h LO=%h busy=%b exp 0 0 0", HI, LO, busy);
      end
      $display("reset abort HI=%h LO=%h busy=%b", HI, LO, busy);
      run_op(4'd4, 32'd3, 32'd4);
      checks++;
      if (LO !== 32'd12 || HI !== 32'd0) begin
         errors++;
         $display("FAIL abort_multu got HI=%h LO=%h exp HI=0 LO=c", HI, LO);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] op;
      for (int i = 0; i < 8; i++) begin
         case ($urandom_range(0, 3))
            0:       op = 4'd4;
            1:       op = 4'd6;
            2:       op = 4'd5;
            default: op = 4'd7;
         endcase
         run_op(op, $urandom, (i == 3) ? 32'd0 : $urandom_range(1, 32'hFFFF) * (($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'd1));
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_mt_read();
      test_div();
      test_ignore_in_busy();
      test_reset_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
